jk_bank_seq: RTL and testbench
==============================

JK_BANK_SEQ -- requirements
Module: jk_bank_seq

Interface
REQ-001 Parameter NBITS, default 4, width of the JK register bank.
REQ-002 Parameter IDXW, default 2, target-index width; NBITS SHALL equal 2**IDXW.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 R  input  1  reset; asynchronous, active-low.
REQ-005 req0  input  1  requester 0 command request.
REQ-006 op0  input  2  requester 0 op: 00 hold, 01 reset (J0K1), 10 set (J1K0), 11 toggle (J1K1).
REQ-007 idx0  input  IDXW  requester 0 target bit.
REQ-008 req1, op1, idx1  input  1/2/IDXW  requester 1, same meaning as requester 0.
REQ-009 gnt  output  2  one-hot grant; bit n acknowledges requester n.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle completion strobe.
REQ-012 err  output  1  check result; valid only while done is high.
REQ-013 q  output  NBITS  current bank contents.

Function
REQ-014 The block SHALL sequence a bank of NBITS JK flip-flops, one command at a time, through states IDLE -> SETUP -> PULSE -> CHECK -> IDLE.
REQ-015 In IDLE with any req high, the next edge SHALL latch the winner's op and idx, compute the expected bit, enter SETUP and register the grant.
REQ-016 The expected bit SHALL be: q[idx] for hold, 0 for reset, 1 for set, and ~q[idx] for toggle, sampled at the latch edge.
REQ-017 The gnt bit of the winner SHALL be high for exactly the SETUP cycle.
REQ-018 Requesters SHALL hold op and idx stable while req is high and SHALL drop req in the cycle after seeing gnt; a req still high on return to IDLE SHALL be treated as a new request.
REQ-019 Arbitration SHALL be round-robin: with both reqs high, the winner is the requester not granted last; after reset, req0 wins the first tie.
REQ-020 A lone request SHALL win regardless of the round-robin pointer.
REQ-021 SETUP SHALL drive J/K of bit idx per op and J=K=0 on all other bits; the bank enable SHALL be low.
REQ-022 PULSE SHALL assert the bank enable for exactly one cycle with J/K unchanged; only bit idx SHALL update, at the PULSE->CHECK edge.
REQ-023 CHECK SHALL assert done for one cycle and set err = (q[idx] != expected).
REQ-024 Latency SHALL be 3 cycles from the grant edge to the done cycle; back-to-back commands SHALL complete at most every 4 cycles.
REQ-025 Requests arriving while busy SHALL NOT be granted until the next IDLE cycle.
REQ-026 The winner's op/idx SHALL be taken only at the latch edge; changes made afterwards SHALL NOT affect the command in flight.
REQ-027 gnt, done and err SHALL be low in every state not listed above.

Reset
REQ-028 With R low, the block SHALL asynchronously force state IDLE, q=0, gnt=00, done=0, err=0, busy=0, and the round-robin pointer to favour req0.
REQ-029 Reset asserted mid-sequence SHALL abort the command with no done strobe; no bank update SHALL occur.
REQ-030 Release of R SHALL be honoured at the next rising edge; the first arbitration SHALL occur no earlier than that edge.

Structure
REQ-031 Package jk_bank_seq_pkg SHALL hold the op-code constants (HOLD, RST, SET, TGL), the state enum, and the NBITS default.
REQ-032 Sub-module jk_bank SHALL contain NBITS enabled JK flip-flops with per-bit J/K, a shared enable and asynchronous active-low clear; the controller SHALL contain only the FSM, arbiter and checker.

Verification
REQ-033 After reset release: req0=1, op0=10, idx0=2 -> gnt=01 for one cycle, done three cycles later, q=0100, err=0.
REQ-034 From q=0100: req0 toggle idx 2, then hold idx 2, then toggle idx 2 -> q goes 0000, then 0000, then 0100, with err=0 on each done.
REQ-035 req0 and req1 both held high, each re-raising req after its grant -> grants alternate 01, 10, 01, 10, with the first grant 01.
REQ-036 With q=1111: req1 op 01 idx 3 -> q=0111, err=0; the other bits are unchanged.
REQ-037 Assert R low during PULSE -> q=0000, no done, busy=0; the next req0 set idx 0 completes with q=0001.
REQ-038 Raise req1 while busy -> no gnt until the cycle after IDLE is re-entered, then gnt=10.

Source files
------------

// File: rtl/jk_bank_seq_pkg.sv
// Shared definitions for the JK bank sequencer: op codes, controller states
// and the helper that predicts a bit's value after a command.
package jk_bank_seq_pkg;

    localparam int NBITS_DEFAULT = 4;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TGL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SETUP = 2'b01,
        ST_PULSE = 2'b10,
        ST_CHECK = 2'b11
    } state_t;

    function automatic logic expected_bit(input logic [1:0] op, input logic cur);
        logic res;
        case (op)
            HOLD:    res = cur;
            RST:     res = 1'b0;
            SET:     res = 1'b1;
            default: res = ~cur;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/jk_bank_seq_jk_bank.sv
// Bank of NBITS JK flip-flops with per-bit J/K, a shared enable and an
// asynchronous active-low clear.
module jk_bank #(
    parameter int NBITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [NBITS-1:0] j,
    input  logic [NBITS-1:0] k,
    output logic [NBITS-1:0] q
);

    logic [NBITS-1:0] q_q;
    logic [NBITS-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            for (int i = 0; i < NBITS; i++) begin
                case ({j[i], k[i]})
                    2'b01:   q_d[i] = 1'b0;
                    2'b10:   q_d[i] = 1'b1;
                    2'b11:   q_d[i] = ~q_q[i];
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_bank_seq.sv
// Sequencer that arbitrates two requesters round-robin and applies one JK
// command at a time to the bank, then checks the targeted bit.
module jk_bank_seq
    import jk_bank_seq_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             R,
    input  logic             req0,
    input  logic [1:0]       op0,
    input  logic [IDXW-1:0]  idx0,
    input  logic             req1,
    input  logic [1:0]       op1,
    input  logic [IDXW-1:0]  idx1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NBITS-1:0] q
);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              exp_q, exp_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              prio_q, prio_d;

    logic              win1;
    logic [1:0]        sel_op;
    logic [IDXW-1:0]   sel_idx;
    logic [NBITS-1:0]  bank_j;
    logic [NBITS-1:0]  bank_k;
    logic              bank_en;

    // prio_q high means requester 1 wins the next tie
    assign win1    = req1 && (!req0 || prio_q);
    assign sel_op  = win1 ? op1 : op0;
    assign sel_idx = win1 ? idx1 : idx0;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        exp_d   = exp_q;
        gnt_d   = 2'b00;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    op_d    = sel_op;
                    idx_d   = sel_idx;
                    exp_d   = expected_bit(sel_op, q[sel_idx]);
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                    prio_d  = !win1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_PULSE;
            ST_PULSE: state_d = ST_CHECK;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= ST_IDLE;
            op_q    <= HOLD;
            idx_q   <= '0;
            exp_q   <= 1'b0;
            gnt_q   <= 2'b00;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

    // J/K are presented in SETUP and held through PULSE so the enable sees stable inputs
    always_comb begin
        bank_j = '0;
        bank_k = '0;
        if (state_q == ST_SETUP || state_q == ST_PULSE) begin
            bank_j[idx_q] = op_q[1];
            bank_k[idx_q] = op_q[0];
        end
    end

    assign bank_en = (state_q == ST_PULSE);

    jk_bank #(.NBITS(NBITS)) u_bank (
        .clk   (clk),
        .rst_n (R),
        .en    (bank_en),
        .j     (bank_j),
        .k     (bank_k),
        .q     (q)
    );

    assign gnt  = gnt_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_CHECK);
    assign err  = done && (q[idx_q] != exp_q);

endmodule

// File: tb/tb_jk_bank_seq.sv
// Directed self-checking bench for jk_bank_seq: reset, single commands,
// round-robin arbitration, mid-sequence reset and busy-time requests.
module tb_jk_bank_seq;

    logic       clk;
    logic       R;
    logic       req0;
    logic [1:0] op0;
    logic [1:0] idx0;
    logic       req1;
    logic [1:0] op1;
    logic [1:0] idx1;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] q;

    int checks   = 0;
    int failures = 0;

    jk_bank_seq #(.NBITS(4), .IDXW(2)) dut (
        .clk  (clk),
        .R    (R),
        .req0 (req0),
        .op0  (op0),
        .idx0 (idx0),
        .req1 (req1),
        .op1  (op1),
        .idx1 (idx1),
        .gnt  (gnt),
        .busy (busy),
        .done (done),
        .err  (err),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit which, input logic [1:0] op, input logic [1:0] idx);
        req0 = (which == 1'b0);
        req1 = (which == 1'b1);
        op0  = op;
        op1  = op;
        idx0 = idx;
        idx1 = idx;
    endtask

    // Full command from IDLE; op/idx are scrambled after the grant to prove they were latched
    task automatic runCommand(input bit which, input logic [1:0] op, input logic [1:0] idx,
                              input logic [3:0] exp_q);
        logic [1:0] exp_gnt;
        exp_gnt = which ? 2'b10 : 2'b01;
        applyStimulus(which, op, idx);
        stepClock();
        checkOutput("gnt_setup", gnt, exp_gnt);
        checkOutput("busy_setup", busy, 1);
        checkOutput("done_setup", done, 0);
        req0 = 0;
        req1 = 0;
        op0  = ~op;
        op1  = ~op;
        idx0 = idx + 2'd1;
        idx1 = idx + 2'd1;
        stepClock();
        checkOutput("gnt_pulse", gnt, 0);
        checkOutput("done_pulse", done, 0);
        stepClock();
        checkOutput("done_check", done, 1);
        checkOutput("err_check", err, 0);
        checkOutput("q_check", q, exp_q);
        checkOutput("gnt_check", gnt, 0);
        stepClock();
        checkOutput("done_idle", done, 0);
        checkOutput("busy_idle", busy, 0);
    endtask

    initial begin
        R = 0; req0 = 0; req1 = 0; op0 = 0; op1 = 0; idx0 = 0; idx1 = 0;
        #1;
        stepClock();
        checkOutput("rst_q", q, 0);
        checkOutput("rst_gnt", gnt, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        R = 1;

        // Set, toggle, hold, toggle on bit 2
        runCommand(0, 2'b10, 2'd2, 4'b0100);
        runCommand(0, 2'b11, 2'd2, 4'b0000);
        runCommand(0, 2'b00, 2'd2, 4'b0000);
        runCommand(0, 2'b11, 2'd2, 4'b0100);

        // Round-robin after a fresh reset: grants 01,10,01,10
        R = 0;
        #1;
        checkOutput("rst2_q", q, 0);
        stepClock();
        R = 1;
        req0 = 1; op0 = 2'b10; idx0 = 2'd0;
        req1 = 1; op1 = 2'b10; idx1 = 2'd1;
        for (int n = 0; n < 4; n++) begin
            stepClock();
            checkOutput("rr_gnt", gnt, (n % 2 == 1) ? 2'b10 : 2'b01);
            if (n % 2 == 1) req1 = 0; else req0 = 0;
            stepClock();
            req0 = 1;
            req1 = 1;
            stepClock();
            checkOutput("rr_done", done, 1);
            checkOutput("rr_err", err, 0);
            stepClock();
        end
        req0 = 0;
        req1 = 0;
        checkOutput("rr_q", q, 4'b0011);

        // Fill the bank then clear bit 3 from requester 1
        runCommand(0, 2'b10, 2'd2, 4'b0111);
        runCommand(0, 2'b10, 2'd3, 4'b1111);
        runCommand(1, 2'b01, 2'd3, 4'b0111);

        // Reset during PULSE aborts the toggle of bit 3
        applyStimulus(0, 2'b11, 2'd3);
        stepClock();
        checkOutput("abort_gnt", gnt, 2'b01);
        req0 = 0;
        stepClock();
        checkOutput("abort_busy_pulse", busy, 1);
        R = 0;
        #1;
        checkOutput("abort_q", q, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_gnt_low", gnt, 0);
        stepClock();
        checkOutput("abort_done_later", done, 0);
        R = 1;
        stepClock();
        checkOutput("abort_idle_done", done, 0);
        checkOutput("abort_idle_q", q, 0);
        runCommand(0, 2'b10, 2'd0, 4'b0001);

        // req1 raised while busy is held off until IDLE is re-entered
        applyStimulus(0, 2'b00, 2'd0);
        stepClock();
        checkOutput("busy_gnt0", gnt, 2'b01);
        req0 = 0;
        stepClock();
        req1 = 1; op1 = 2'b10; idx1 = 2'd3;
        #1;
        checkOutput("busy_pulse_gnt", gnt, 0);
        stepClock();
        checkOutput("busy_check_gnt", gnt, 0);
        checkOutput("busy_check_done", done, 1);
        checkOutput("busy_check_q", q, 4'b0001);
        stepClock();
        checkOutput("busy_idle_gnt", gnt, 0);
        checkOutput("busy_idle_busy", busy, 0);
        stepClock();
        checkOutput("busy_late_gnt", gnt, 2'b10);
        req1 = 0;
        stepClock();
        stepClock();
        checkOutput("busy_late_done", done, 1);
        checkOutput("busy_late_err", err, 0);
        checkOutput("busy_late_q", q, 4'b1001);
        stepClock();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
